// File: rtl/sub_pkg.sv
// sub_pkg: FSM state type and counter sizing helper shared by the serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fsub_1bit.sv
// fsub_1bit: single-bit full subtractor cell, d = a - b - bin with borrow-out.
module fsub_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb;

    assign axb  = a ^ b;
    assign d    = axb ^ bin;
    assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, LSB first, one bit per clock.
// Result and borrow are registered and only update on entry to DONE.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, acc_q, acc_d, r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d, borrow_q, borrow_d;
    logic             d, bout, last;

    fsub_1bit u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (bor_q),
        .d    (d),
        .bout (bout)
    );

    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        r_d      = r_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                sa_d    = a;
                sb_d    = b;
                acc_d   = '0;
                cnt_d   = '0;
                bor_d   = 1'b0;
            end
            RUN: begin
                // difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                acc_d = (acc_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
                bor_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d  = DONE;
                    r_d      = acc_d;
                    borrow_d = bout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            r_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            r_q      <= r_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign r      = r_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and exhaustive checks of serial_sub at WIDTH 1, 4 and 8
// using a queue of expected results popped when done pulses.
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       st1, a1, b1, r1, busy1, done1, bo1;
    logic       st4, busy4, done4, bo4;
    logic [3:0] a4, b4, r4;
    logic       st8, busy8, done8, bo8;
    logic [7:0] a8, b8, r8;

    typedef struct {
        logic [7:0] r;
        logic       bo;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .r(r1), .borrow(bo1));
    serial_sub #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .r(r4), .borrow(bo4));
    serial_sub #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .r(r8), .borrow(bo8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic f_done(input int w);
        return w == 1 ? done1 : w == 4 ? done4 : done8;
    endfunction

    function automatic logic f_busy(input int w);
        return w == 1 ? busy1 : w == 4 ? busy4 : busy8;
    endfunction

    function automatic logic f_bo(input int w);
        return w == 1 ? bo1 : w == 4 ? bo4 : bo8;
    endfunction

    function automatic logic [7:0] f_r(input int w);
        return w == 1 ? {7'b0, r1} : w == 4 ? {4'b0, r4} : r8;
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (w == 1) begin
            st1 = s; a1 = a[0]; b1 = b[0];
        end else if (w == 4) begin
            st4 = s; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            st8 = s; a8 = a; b8 = b;
        end
    endtask

    task automatic push(input int w, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] m;
        logic [7:0] am, bm;
        exp_t       e;
        m    = (9'd1 << w) - 9'd1;
        am   = a & m[7:0];
        bm   = b & m[7:0];
        e.r  = (am - bm) & m[7:0];
        e.bo = am < bm;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int w, output int n, output int bc);
        n  = 1;
        bc = 0;
        @(negedge clk);
        if (f_busy(w)) bc++;
        while (!f_done(w) && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (f_busy(w)) bc++;
        end
    endtask

    task automatic op(input int w, input logic [7:0] a, input logic [7:0] b);
        int   n, bc;
        exp_t e;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        push(w, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, ~a, ~b);
        wait_done(w, n, bc);
        chk("latency", n, w + 1);
        chk("busy_cycles", bc, w + 1);
        e = sb.pop_front();
        chk("r", f_r(w), e.r);
        chk("borrow", f_bo(w), e.bo);
        @(negedge clk);
        chk("done_pulse", f_done(w), 0);
        chk("idle", f_busy(w), 0);
        chk("r_hold", f_r(w), e.r);
    endtask

    initial begin
        int   ws[3] = '{1, 4, 8};
        int   n, bc, pulses;
        exp_t e;
        drive(1, 1'b0, 8'h0, 8'h0);
        drive(4, 1'b0, 8'h0, 8'h0);
        drive(8, 1'b0, 8'h0, 8'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        foreach (ws[i]) begin
            chk("rst_busy", f_busy(ws[i]), 0);
            chk("rst_done", f_done(ws[i]), 0);
            chk("rst_r", f_r(ws[i]), 0);
            chk("rst_borrow", f_bo(ws[i]), 0);
        end
        rst = 1'b0;

        op(4, 8'd9, 8'd3);
        op(4, 8'd3, 8'd9);
        op(4, 8'd0, 8'd1);
        op(4, 8'd15, 8'd15);

        @(negedge clk);
        drive(4, 1'b1, 8'd7, 8'd2);
        for (int k = 0; k < 3; k++) begin
            push(4, 8'd7, 8'd2);
            @(posedge clk);
            #1 drive(4, k < 2, 8'($urandom), 8'($urandom));
            wait_done(4, n, bc);
            chk("b2b_latency", n, 5);
            e = sb.pop_front();
            chk("b2b_r", r4, e.r);
            chk("b2b_borrow", bo4, e.bo);
            drive(4, k < 2, 8'd7, 8'd2);
            @(negedge clk);
            chk("b2b_idle", busy4, 0);
        end
        @(negedge clk);
        chk("b2b_stop", busy4, 0);

        op(4, 8'd3, 8'd9);
        @(negedge clk);
        drive(4, 1'b1, 8'd9, 8'd3);
        @(posedge clk);
        #1 drive(4, 1'b0, 8'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1 chk("pre_rst_r", r4, 4'hA);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_done", done4, 0);
        chk("mid_rst_r", r4, 0);
        chk("mid_rst_borrow", bo4, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(done4);
        end
        chk("no_done_after_rst", pulses, 0);
        op(4, 8'd8, 8'd1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op(4, 8'(a), 8'(b));

        op(1, 8'd1, 8'd0);
        op(1, 8'd0, 8'd1);
        op(1, 8'd1, 8'd1);
        op(1, 8'd0, 8'd0);

        op(8, 8'd200, 8'd55);
        op(8, 8'd3, 8'd9);
        op(8, 8'd0, 8'd1);
        op(8, 8'd255, 8'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
